// File: rtl/lc3b_mem_arbiter_pkg.sv
// lc3b_mem_arbiter_pkg
// Shared types and constants for the LC-3b memory arbiter slice.
//   lc3b_word / lc3b_mem_wmask : default bus word and write-mask types
//   ARB_*_DEFAULT              : default arbiter geometry
//   lc3b_arb_state, ARB_IDLE/ARB_BUSY : arbiter FSM encoding
//   arb_wrap()                 : (base + off) mod n, used for ring arithmetic
package lc3b_mem_arbiter_pkg;

    localparam int unsigned ARB_NUM_PORTS_DEFAULT  = 2;
    localparam int unsigned ARB_ADDR_WIDTH_DEFAULT = 16;
    localparam int unsigned ARB_DATA_WIDTH_DEFAULT = 16;

    typedef logic [ARB_ADDR_WIDTH_DEFAULT-1:0]     lc3b_word;
    typedef logic [ARB_DATA_WIDTH_DEFAULT/8-1:0]   lc3b_mem_wmask;

    typedef logic [0:0] lc3b_arb_state;
    localparam lc3b_arb_state ARB_IDLE = 1'b0;
    localparam lc3b_arb_state ARB_BUSY = 1'b1;

    function automatic int unsigned arb_wrap(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// lc3b_mem_arbiter_if
// Bundles the requester-side and memory-side read/write/resp handshakes.
//   req_read/req_write/req_address/req_wdata/req_byte_enable : per-port requests
//   req_resp (one-hot), req_rdata (broadcast)                : per-port completion
//   mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable : downstream request
//   mem_resp, mem_rdata                                      : downstream completion
// slave  = the arbiter's view; master = the environment (requesters + memory).
interface lc3b_mem_arbiter_if
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = ARB_NUM_PORTS_DEFAULT,
    parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH_DEFAULT
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                 req_read;
    logic [NUM_PORTS-1:0]                 req_write;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0][MASK_WIDTH-1:0] req_byte_enable;
    logic [NUM_PORTS-1:0]                 req_resp;
    logic [DATA_WIDTH-1:0]                req_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, req_byte_enable,
        output req_resp, req_rdata,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, req_byte_enable,
        input  req_resp, req_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/lc3b_mem_arbiter_rr_select.sv
// arbiter_rr_select
// Combinational round-robin picker: first pending port at or after ptr,
// wrapping from NUM_PORTS-1 back to 0.
//   pending : per-port request vector
//   ptr     : highest-priority port index this round
//   valid   : any port pending
//   index   : selected port (meaningful only when valid)
module arbiter_rr_select
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = ARB_NUM_PORTS_DEFAULT
) (
    input  logic [NUM_PORTS-1:0]         pending,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic                         valid,
    output logic [$clog2(NUM_PORTS)-1:0] index
);
    localparam int unsigned IDX_WIDTH = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] rotated;
    int unsigned          first;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the
    // offset back. Modulo arithmetic keeps non-power-of-2 counts correct.
    always_comb begin
        rotated = '0;
        valid   = 1'b0;
        first   = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            rotated[i] = pending[IDX_WIDTH'(arb_wrap(32'(ptr), i, NUM_PORTS))];
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                first = i;
            end
        end
        index = IDX_WIDTH'(arb_wrap(32'(ptr), first, NUM_PORTS));
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// N-port round-robin arbiter in front of one LC-3b memory port. The winner's
// request is captured on grant and replayed to memory until mem_resp.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : requester and memory handshakes (slave modport)
//   busy       : high while a transaction is outstanding
//   grant_id   : port being served, 0 when idle
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = ARB_NUM_PORTS_DEFAULT,
    parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    lc3b_mem_arbiter_if.slave            bus,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = $clog2(NUM_PORTS);

    lc3b_arb_state         state;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  cur_id;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [MASK_WIDTH-1:0] lat_byte_enable;

    logic [NUM_PORTS-1:0]  pending;
    logic                  sel_valid;
    logic [IDX_WIDTH-1:0]  sel_id;

    assign pending = bus.req_read | bus.req_write;

    arbiter_rr_select #(.NUM_PORTS(NUM_PORTS)) u_select (
        .pending (pending),
        .ptr     (ptr),
        .valid   (sel_valid),
        .index   (sel_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ARB_IDLE;
            ptr             <= '0;
            cur_id          <= '0;
            op_write        <= 1'b0;
            lat_address     <= '0;
            lat_wdata       <= '0;
            lat_byte_enable <= '0;
        end else if (state == ARB_IDLE) begin
            if (sel_valid) begin
                cur_id          <= sel_id;
                // read+write on one port resolves to the write
                op_write        <= bus.req_write[sel_id];
                lat_address     <= bus.req_address[sel_id];
                lat_wdata       <= bus.req_wdata[sel_id];
                lat_byte_enable <= bus.req_byte_enable[sel_id];
                state           <= ARB_BUSY;
            end
        end else begin
            if (bus.mem_resp) begin
                ptr   <= IDX_WIDTH'(arb_wrap(32'(cur_id), 1, NUM_PORTS));
                state <= ARB_IDLE;
            end
        end
    end

    assign busy     = (state == ARB_BUSY);
    assign grant_id = busy ? cur_id : '0;

    assign bus.mem_read        = busy & ~op_write;
    assign bus.mem_write       = busy &  op_write;
    assign bus.mem_address     = lat_address;
    assign bus.mem_wdata       = lat_wdata;
    assign bus.mem_byte_enable = lat_byte_enable;

    // Completion is a same-cycle pass-through; reset suppresses it so an
    // abandoned transaction never reports back.
    always_comb begin
        bus.req_resp = '0;
        if (busy && bus.mem_resp && !reset) begin
            bus.req_resp[cur_id] = 1'b1;
        end
    end

    assign bus.req_rdata = bus.mem_rdata;

endmodule
